// File: rtl/osd_mam_wb_burst_if.sv
// rtl/osd_mam_wb_burst_if.sv - Wishbone B3 burst master bridging request/write/read streams
module osd_mam_wb_burst_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255,
    localparam int SW        = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_rw,
    input  logic                  req_burst,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [13:0]           req_beats,
    input  logic                  write_valid,
    output logic                  write_ready,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [SW-1:0]         write_strb,
    output logic                  read_valid,
    input  logic                  read_ready,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  stb_o,
    output logic                  cyc_o,
    output logic                  we_o,
    input  logic                  ack_i,
    input  logic                  err_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [2:0]            cti_o,
    output logic [1:0]            bte_o,
    output logic [SW-1:0]         sel_o,
    output logic                  bus_err_o,
    output logic [ADDR_WIDTH-1:0] bus_err_addr_o
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_WAIT = 3'd1;
    localparam logic [2:0] WR_BUS  = 3'd2;
    localparam logic [2:0] RD_BUS  = 3'd3;
    localparam logic [2:0] RD_HOLD = 3'd4;
    localparam logic [2:0] DRAIN   = 3'd5;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_INC = ADDR_WIDTH'(SW);

    logic [2:0]    state;
    logic [13:0]   cnt;
    logic [13:0]   cnt_dec;
    logic          burst;
    logic          rw;
    logic          aborted;
    logic [TW-1:0] tmo;
    logic          timeout_hit;
    logic          bus_fail;
    logic          bus_ok;

    assign cnt_dec     = cnt - 14'd1;
    assign timeout_hit = (TIMEOUT != 0) && stb_o && !ack_i && !err_i && (tmo == TMO_LAST);
    // Error (or timeout) wins over a simultaneous ack.
    assign bus_fail    = stb_o && (err_i || timeout_hit);
    assign bus_ok      = stb_o && ack_i && !err_i;

    assign req_ready   = (state == IDLE);
    assign write_ready = (state == WR_WAIT) || ((state == DRAIN) && rw);
    assign read_valid  = (state == RD_HOLD) || ((state == DRAIN) && !rw);
    assign cti_o       = !cyc_o ? 3'b000 : (!burst || (cnt == 14'd1)) ? 3'b111 : 3'b010;
    assign bte_o       = 2'b00;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            cnt            <= '0;
            burst          <= 1'b0;
            rw             <= 1'b0;
            aborted        <= 1'b0;
            tmo            <= '0;
            stb_o          <= 1'b0;
            cyc_o          <= 1'b0;
            we_o           <= 1'b0;
            sel_o          <= '0;
            addr_o         <= '0;
            dat_o          <= '0;
            read_data      <= '0;
            bus_err_o      <= 1'b0;
            bus_err_addr_o <= '0;
        end else begin
            bus_err_o <= 1'b0;
            tmo       <= (stb_o && !ack_i && !err_i && !timeout_hit) ? tmo + 1'b1 : '0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_o  <= req_addr;
                        rw      <= req_rw;
                        burst   <= req_burst;
                        aborted <= 1'b0;
                        cnt     <= (req_burst && (req_beats != 14'd0)) ? req_beats : 14'd1;
                        cyc_o   <= 1'b1;
                        we_o    <= req_rw;
                        if (req_rw) begin
                            state <= WR_WAIT;
                        end else begin
                            sel_o <= '1;
                            stb_o <= 1'b1;
                            state <= RD_BUS;
                        end
                    end
                end
                WR_WAIT: begin
                    if (write_valid) begin
                        dat_o <= write_data;
                        sel_o <= burst ? {SW{1'b1}} : write_strb;
                        stb_o <= 1'b1;
                        state <= WR_BUS;
                    end
                end
                WR_BUS: begin
                    if (bus_fail) begin
                        stb_o          <= 1'b0;
                        cyc_o          <= 1'b0;
                        we_o           <= 1'b0;
                        bus_err_o      <= 1'b1;
                        bus_err_addr_o <= addr_o;
                        addr_o         <= addr_o + ADDR_INC;
                        cnt            <= cnt_dec;
                        state          <= (cnt_dec == 14'd0) ? IDLE : DRAIN;
                    end else if (bus_ok) begin
                        stb_o  <= 1'b0;
                        addr_o <= addr_o + ADDR_INC;
                        cnt    <= cnt_dec;
                        if (cnt_dec == 14'd0) begin
                            cyc_o <= 1'b0;
                            we_o  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= WR_WAIT;
                        end
                    end
                end
                RD_BUS: begin
                    // A failed read beat is still handed out (as zero) through RD_HOLD.
                    if (bus_fail) begin
                        stb_o          <= 1'b0;
                        cyc_o          <= 1'b0;
                        bus_err_o      <= 1'b1;
                        bus_err_addr_o <= addr_o;
                        addr_o         <= addr_o + ADDR_INC;
                        cnt            <= cnt_dec;
                        read_data      <= '0;
                        aborted        <= 1'b1;
                        state          <= RD_HOLD;
                    end else if (bus_ok) begin
                        stb_o     <= 1'b0;
                        read_data <= dat_i;
                        addr_o    <= addr_o + ADDR_INC;
                        state     <= RD_HOLD;
                    end
                end
                RD_HOLD: begin
                    if (read_ready) begin
                        if (aborted) begin
                            state <= (cnt == 14'd0) ? IDLE : DRAIN;
                        end else begin
                            cnt <= cnt_dec;
                            if (cnt_dec == 14'd0) begin
                                cyc_o <= 1'b0;
                                state <= IDLE;
                            end else begin
                                stb_o <= 1'b1;
                                state <= RD_BUS;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if ((rw && write_valid) || (!rw && read_ready)) begin
                        cnt <= cnt_dec;
                        if (cnt_dec == 14'd0) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_osd_mam_wb_burst_if.sv
// tb/tb_osd_mam_wb_burst_if.sv - scoreboard bench for the Wishbone burst master
module tb_osd_mam_wb_burst_if;

    typedef struct {
        int          delay;
        int          mode;   // 0 ack, 1 err, 2 silent, 3 ack+err
        logic [31:0] data;
    } beat_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [2:0]  cti;
        logic        we;
        logic [31:0] dat;
        bit          chk_dat;
    } wb_exp_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_rw = 1'b0, req_burst = 1'b0;
    logic [31:0] req_addr = '0;
    logic [13:0] req_beats = '0;
    logic        write_valid = 1'b0, write_ready;
    logic [31:0] write_data = '0;
    logic [3:0]  write_strb = '0;
    logic        read_valid, read_ready = 1'b1;
    logic [31:0] read_data;
    logic        stb_o, cyc_o, we_o, ack_i = 1'b0, err_i = 1'b0;
    logic [31:0] addr_o, dat_o, dat_i = '0;
    logic [2:0]  cti_o;
    logic [1:0]  bte_o;
    logic [3:0]  sel_o;
    logic        bus_err_o;
    logic [31:0] bus_err_addr_o;

    osd_mam_wb_burst_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(8)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_burst(req_burst),
        .req_addr(req_addr), .req_beats(req_beats),
        .write_valid(write_valid), .write_ready(write_ready), .write_data(write_data),
        .write_strb(write_strb),
        .read_valid(read_valid), .read_ready(read_ready), .read_data(read_data),
        .stb_o(stb_o), .cyc_o(cyc_o), .we_o(we_o), .ack_i(ack_i), .err_i(err_i),
        .addr_o(addr_o), .dat_o(dat_o), .dat_i(dat_i), .cti_o(cti_o), .bte_o(bte_o),
        .sel_o(sel_o), .bus_err_o(bus_err_o), .bus_err_addr_o(bus_err_addr_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    beat_t       mode_q[$];
    wb_exp_t     wb_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] err_q[$];
    int  acks = 0;
    int  last_run = 0;
    int  cyc_drops = 0;
    int  stb_cycles = 0;
    bit  watch = 1'b0;
    bit  rd_toggle = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void beat(input int delay, input int mode, input logic [31:0] data);
        beat_t b;
        b.delay = delay; b.mode = mode; b.data = data;
        mode_q.push_back(b);
    endfunction

    function automatic void exp_wb(input logic [31:0] a, input logic [3:0] s, input logic [2:0] c,
                                   input logic w, input logic [31:0] d, input bit cd);
        wb_exp_t e;
        e.addr = a; e.sel = s; e.cti = c; e.we = w; e.dat = d; e.chk_dat = cd;
        wb_q.push_back(e);
    endfunction

    // Wishbone slave model: one stb run is one beat, behaviour taken from mode_q.
    beat_t cur;
    bit    active = 1'b0;
    int    waited = 0;
    initial forever begin
        @(posedge clk); #2;
        ack_i = 1'b0; err_i = 1'b0;
        if (rst_i) begin
            active = 1'b0;
        end else if (stb_o) begin
            if (!active) begin
                active = 1'b1;
                waited = 0;
                if (mode_q.size() > 0) cur = mode_q.pop_front();
                else begin cur.delay = 0; cur.mode = 0; cur.data = '0; end
            end
            if (waited >= cur.delay) begin
                dat_i = cur.data;
                ack_i = (cur.mode == 0) || (cur.mode == 3);
                err_i = (cur.mode == 1) || (cur.mode == 3);
            end
            waited++;
        end else if (active) begin
            active = 1'b0;
            last_run = waited;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        read_ready = rd_toggle ? ~read_ready : 1'b1;
    end

    wb_exp_t     e_wb;
    logic [31:0] e_v;
    always @(negedge clk) begin
        if (!rst_i) begin
            if (stb_o && ack_i) acks++;
            if (watch && !cyc_o) cyc_drops++;
            if (watch && stb_o) stb_cycles++;
            if (stb_o && (ack_i || err_i)) begin
                if (wb_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL wb_extra: got beat at %0h expected none", addr_o);
                end else begin
                    e_wb = wb_q.pop_front();
                    chk("wb_addr", addr_o, e_wb.addr);
                    chk("wb_sel", sel_o, e_wb.sel);
                    chk("wb_cti", cti_o, e_wb.cti);
                    chk("wb_we", we_o, e_wb.we);
                    chk("wb_bte", bte_o, 2'b00);
                    if (e_wb.chk_dat) chk("wb_dat", dat_o, e_wb.dat);
                end
            end
            if (read_valid && read_ready) begin
                if (rd_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rd_extra: got %0h expected none", read_data);
                end else begin
                    e_v = rd_q.pop_front();
                    chk("rd_data", read_data, e_v);
                end
            end
            if (bus_err_o) begin
                if (err_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL err_extra: got %0h expected none", bus_err_addr_o);
                end else begin
                    e_v = err_q.pop_front();
                    chk("err_addr", bus_err_addr_o, e_v);
                end
            end
        end
    end

    task automatic do_req(input logic rw, input logic bst, input logic [31:0] a, input logic [13:0] n);
        int k = 0;
        logic hs;
        req_rw = rw; req_burst = bst; req_addr = a; req_beats = n; req_valid = 1'b1;
        do begin
            @(negedge clk); hs = req_ready;
            @(posedge clk); #1; k++;
        end while (!hs && k < 200);
        req_valid = 1'b0;
        chk("req_accept", hs, 1'b1);
    endtask

    task automatic send_write(input logic [31:0] d, input logic [3:0] s, input int gap);
        int k = 0;
        logic hs;
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
        write_data = d; write_strb = s; write_valid = 1'b1;
        do begin
            @(negedge clk); hs = write_ready;
            @(posedge clk); #1; k++;
        end while (!hs && k < 200);
        write_valid = 1'b0;
        chk("wr_accept", hs, 1'b1);
    endtask

    task automatic wait_idle();
        int k = 0;
        do begin @(negedge clk); k++; end while (!(req_ready && !cyc_o) && k < 300);
        chk("idle", {req_ready, cyc_o}, 2'b10);
        @(posedge clk); #1;
    endtask

    initial begin
        int k;
        int a0;
        #200000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        int k;
        int a0;
        // reset values
        #12;
        chk("rst_stb", stb_o, 0); chk("rst_cyc", cyc_o, 0); chk("rst_we", we_o, 0);
        chk("rst_cti", cti_o, 0); chk("rst_sel", sel_o, 0); chk("rst_addr", addr_o, 0);
        chk("rst_dat", dat_o, 0); chk("rst_rdata", read_data, 0); chk("rst_berr", bus_err_o, 0);
        chk("rst_berr_addr", bus_err_addr_o, 0); chk("rst_req_ready", req_ready, 1);
        @(posedge clk); #1; rst_i = 1'b0;

        // single write, partial strobe, ack after 2 cycles
        beat(2, 0, 0);
        exp_wb(32'h100, 4'b0101, 3'b111, 1'b1, 32'hA5A50001, 1'b1);
        do_req(1'b1, 1'b0, 32'h100, 14'd0);
        send_write(32'hA5A50001, 4'b0101, 0);
        k = 0;
        do begin @(negedge clk); k++; end while (!(stb_o && ack_i) && k < 50);
        @(negedge clk);
        chk("cyc_after_ack", cyc_o, 0);
        wait_idle();

        // 4-beat burst read with toggling read_ready
        rd_toggle = 1'b1;
        beat(0, 0, 32'hD0D0_0000); beat(1, 0, 32'hD1D1_1111);
        beat(0, 0, 32'hD2D2_2222); beat(2, 0, 32'hD3D3_3333);
        exp_wb(32'h40, 4'hF, 3'b010, 1'b0, 0, 1'b0);
        exp_wb(32'h44, 4'hF, 3'b010, 1'b0, 0, 1'b0);
        exp_wb(32'h48, 4'hF, 3'b010, 1'b0, 0, 1'b0);
        exp_wb(32'h4C, 4'hF, 3'b111, 1'b0, 0, 1'b0);
        rd_q.push_back(32'hD0D0_0000); rd_q.push_back(32'hD1D1_1111);
        rd_q.push_back(32'hD2D2_2222); rd_q.push_back(32'hD3D3_3333);
        do_req(1'b0, 1'b1, 32'h40, 14'd4);
        wait_idle();
        rd_toggle = 1'b0;

        // 3-beat burst write with gaps on write_valid
        beat(0, 0, 0); beat(0, 0, 0); beat(0, 0, 0);
        exp_wb(32'h200, 4'hF, 3'b010, 1'b1, 32'h0000_0200, 1'b1);
        exp_wb(32'h204, 4'hF, 3'b010, 1'b1, 32'h0000_0204, 1'b1);
        exp_wb(32'h208, 4'hF, 3'b111, 1'b1, 32'h0000_0208, 1'b1);
        a0 = acks; cyc_drops = 0; stb_cycles = 0;
        do_req(1'b1, 1'b1, 32'h200, 14'd3);
        watch = 1'b1;
        send_write(32'h0000_0200, 4'h1, 0);
        send_write(32'h0000_0204, 4'h2, 3);
        send_write(32'h0000_0208, 4'h4, 2);
        k = 0;
        while (acks < a0 + 3 && k < 100) begin @(posedge clk); k++; end
        watch = 1'b0;
        chk("burst_wr_cyc_drops", cyc_drops, 0);
        chk("burst_wr_stb_cycles", stb_cycles, 3);
        wait_idle();
        chk("burst_wr_acks", acks - a0, 3);

        // burst read, error on beat 2: remaining beats come back as zero
        beat(0, 0, 32'h1111_1111); beat(1, 1, 32'hBADBAD00);
        exp_wb(32'h80, 4'hF, 3'b010, 1'b0, 0, 1'b0);
        exp_wb(32'h84, 4'hF, 3'b010, 1'b0, 0, 1'b0);
        rd_q.push_back(32'h1111_1111); rd_q.push_back(0); rd_q.push_back(0); rd_q.push_back(0);
        err_q.push_back(32'h84);
        do_req(1'b0, 1'b1, 32'h80, 14'd4);
        wait_idle();

        // silent slave: timeout after 8 stb cycles
        beat(0, 2, 0);
        rd_q.push_back(0);
        err_q.push_back(32'h300);
        do_req(1'b0, 1'b0, 32'h300, 14'd1);
        wait_idle();
        chk("timeout_len", last_run, 8);

        // ack and err together count as an error
        beat(1, 3, 0);
        exp_wb(32'h310, 4'b0011, 3'b111, 1'b1, 32'hCAFE_0310, 1'b1);
        err_q.push_back(32'h310);
        do_req(1'b1, 1'b0, 32'h310, 14'd0);
        send_write(32'hCAFE_0310, 4'b0011, 0);
        wait_idle();

        // burst write error on beat 1: last two beats are drained
        beat(0, 1, 0);
        exp_wb(32'h400, 4'hF, 3'b010, 1'b1, 32'h0000_0400, 1'b1);
        err_q.push_back(32'h400);
        a0 = acks;
        do_req(1'b1, 1'b1, 32'h400, 14'd3);
        send_write(32'h0000_0400, 4'hF, 0);
        send_write(32'h0000_0404, 4'hF, 1);
        send_write(32'h0000_0408, 4'hF, 0);
        wait_idle();
        chk("drain_acks", acks - a0, 0);

        // reset mid-burst, then a fresh request
        beat(20, 0, 32'h5555_5555);
        do_req(1'b0, 1'b1, 32'h500, 14'd4);
        repeat (2) @(posedge clk);
        #3;
        chk("stb_before_rst", stb_o, 1);
        rst_i = 1'b1;
        #1;
        chk("arst_stb", stb_o, 0); chk("arst_cyc", cyc_o, 0); chk("arst_addr", addr_o, 0);
        chk("arst_cti", cti_o, 0); chk("arst_sel", sel_o, 0); chk("arst_rvalid", read_valid, 0);
        mode_q.delete();
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("req_ready_after_rst", req_ready, 1);
        @(posedge clk); #1;
        beat(0, 0, 32'h6666_6666);
        exp_wb(32'h600, 4'hF, 3'b111, 1'b0, 0, 1'b0);
        rd_q.push_back(32'h6666_6666);
        do_req(1'b0, 1'b0, 32'h600, 14'd1);
        wait_idle();

        repeat (3) @(posedge clk);
        chk("wb_q_empty", wb_q.size(), 0);
        chk("rd_q_empty", rd_q.size(), 0);
        chk("err_q_empty", err_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/osd_mam_wb_burst_if.md
OSD_MAM_WB_BURST_IF -- requirements
Module: osd_mam_wb_burst_if

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: data bus width in bits; legal values 8/16/32/64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: byte address width.
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum cycles stb_o is high without termination; 0 disables the timeout.
REQ-004 SHALL derive localparam SW = DATA_WIDTH/8, the byte-select width.
REQ-005 SHALL have clk_i, input, 1: sole clock; all logic on rising edge.
REQ-006 SHALL have rst_i, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have req_valid/req_ready/req_rw/req_burst: in/out/in/in, 1 each: request handshake; req_rw 1 = write, req_burst 1 = incremental burst.
REQ-008 SHALL have req_addr, in, ADDR_WIDTH: base byte address; req_beats, in, 14: burst length in words.
REQ-009 SHALL have write_valid/write_ready: in/out, 1; write_data, in, DATA_WIDTH; write_strb, in, SW.
REQ-010 SHALL have read_valid/read_ready: out/in, 1; read_data, out, DATA_WIDTH.
REQ-011 SHALL have Wishbone B3 master ports: stb_o, cyc_o, we_o out 1; ack_i, err_i in 1; addr_o out ADDR_WIDTH; dat_o out DATA_WIDTH; dat_i in DATA_WIDTH; cti_o out 3; bte_o out 2; sel_o out SW.
REQ-012 SHALL have bus_err_o, out, 1: one-cycle pulse per failed bus beat; bus_err_addr_o, out, ADDR_WIDTH: address of that beat.

Function
REQ-013 SHALL implement states IDLE, WR_WAIT, WR_BUS, RD_BUS, RD_HOLD, DRAIN.
REQ-014 SHALL drive req_ready=1 only in IDLE; a request is accepted on req_valid&req_ready.
REQ-015 SHALL load the beat counter with req_beats for bursts, and with 1 for single accesses or req_beats==0.
REQ-016 SHALL latch addr_o=req_addr on acceptance and add SW to addr_o after every terminated beat.
REQ-017 SHALL, on write acceptance, enter WR_WAIT with cyc_o=1, we_o=1, stb_o=0.
REQ-018 SHALL assert write_ready only in WR_WAIT and DRAIN; in WR_WAIT a write_valid&write_ready registers dat_o and sel_o, and enters WR_BUS with stb_o=1 next cycle.
REQ-019 SHALL drive sel_o=write_strb for single writes, and all-ones for burst writes and all reads.
REQ-020 SHALL hold stb_o, dat_o, addr_o, sel_o and cti_o stable in WR_BUS/RD_BUS until ack_i, err_i or timeout.
REQ-021 SHALL, on ack_i in WR_BUS, decrement the counter; if the result is 0, go to IDLE with cyc_o=0, stb_o=0, cti_o=000, else return to WR_WAIT.
REQ-022 SHALL, on read acceptance, enter RD_BUS with cyc_o=1, stb_o=1, we_o=0.
REQ-023 SHALL, on ack_i in RD_BUS, capture dat_i into read_data, drop stb_o, and enter RD_HOLD with cyc_o kept high.
REQ-024 SHALL drive read_valid=1 only in RD_HOLD and DRAIN (read); on read_ready, decrement the counter and go to IDLE (cyc_o=0) if 0, else to RD_BUS.
REQ-025 SHALL drive cti_o=111 when the remaining count is 1 or the access is single, 010 otherwise; bte_o SHALL be 00 always.
REQ-026 SHALL count consecutive stb_o-high cycles without ack_i/err_i; reaching TIMEOUT (nonzero) SHALL be treated as err_i.
REQ-027 SHALL give err_i (or timeout) priority over a simultaneous ack_i.
REQ-028 SHALL, on error, pulse bus_err_o and load bus_err_addr_o=addr_o next cycle, drop cyc_o/stb_o, and decrement the counter.
REQ-029 SHALL, after an error with a nonzero remaining count, enter DRAIN.
REQ-030 SHALL, in DRAIN, consume remaining write beats (write_ready=1, data discarded) or return remaining read beats as zero data; it SHALL return to IDLE when the count reaches 0.
REQ-031 SHALL, after an error with zero remaining count, go directly to IDLE.
REQ-032 SHALL, for a read error beat, present read_data=0 with read_valid as a normal beat, so the stream length always equals the requested beats.

Reset
REQ-033 SHALL, while rst_i is high, immediately force state IDLE.
REQ-034 SHALL, while rst_i is high, force stb_o, cyc_o, we_o, cti_o, bte_o, sel_o, addr_o, dat_o, read_data, bus_err_o, bus_err_addr_o, the counter and the timeout counter to 0.
REQ-035 SHALL, on reset mid-transfer, abandon the cycle without further handshakes; req_ready SHALL be 1 on the first cycle after rst_i deasserts.

Verification
REQ-036 Single write, addr 0x100, strb 0101, ack after 2 cycles -> one beat, sel_o=0101, cti_o=111, cyc_o low the cycle after ack.
REQ-037 Burst read of 4 beats at 0x40, DATA_WIDTH=32, read_ready toggling -> addr_o sequence 0x40/44/48/4C; cti_o 010,010,010,111; 4 read beats in order.
REQ-038 Burst write of 3 beats with write_valid gaps -> stb_o low during gaps, cyc_o continuously high, exactly 3 acks.
REQ-039 Burst read of 4 beats, err_i on beat 2 -> bus_err_o pulse with addr base+SW; beats 2-4 returned as zero; IDLE afterward.
REQ-040 TIMEOUT=8, no ack -> error after 8 stb cycles; ack_i and err_i asserted together -> treated as error.
REQ-041 rst_i asserted mid-burst -> all outputs 0 asynchronously; a new request is accepted after release.
